mux2_arb: RTL and testbench
===========================

Name: mux2_arb

Overview:
- Two-requester round-robin arbiter and sequencer for a shared 2:1 datapath mux.
- Grants the output channel to one source per burst and drives the mux select (o_sel).
- Passes the granted source's valid/data/last downstream with valid/ready handshakes on both sides.
- Sits between two producer streams and a single downstream consumer.

Parameters:
- DW, 8, data width of each input and of the output.
- MAX_BEATS, 16, max beats per grant before forced release (fairness bound); must be >= 1.
- CNT_W, 16, width of grant statistics counters (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid0  in  1  requester 0 beat valid.
- i_data0  in  DW  requester 0 beat data.
- i_last0  in  1  requester 0 last beat of burst.
- o_ready0  out  1  requester 0 beat accepted.
- i_valid1  in  1  requester 1 beat valid.
- i_data1  in  DW  requester 1 beat data.
- i_last1  in  1  requester 1 last beat of burst.
- o_ready1  out  1  requester 1 beat accepted.
- o_valid  out  1  downstream beat valid.
- o_data  out  DW  downstream data, muxed by o_sel.
- o_last  out  1  downstream last, muxed by o_sel.
- i_ready  in  1  downstream ready.
- o_sel  out  1  current owner (0/1); select for the shared mux.
- o_busy  out  1  a grant is active.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: FSM = IDLE, o_sel = 0, o_busy = 0, rr_last = 1 (requester 0 wins the first contest), beat counter = 0, o_valid = 0, o_ready0/1 = 0.
- FSM states: IDLE and BUSY.
- IDLE, no valid: stay in IDLE.
- IDLE, exactly one valid: register o_sel = that index and go to BUSY next cycle.
- IDLE, both valid: grant index = ~rr_last.
- Arbitration bubble: exactly 1 cycle from first valid in IDLE to o_valid. No beat is transferred in IDLE (o_ready0/1 = 0).
- BUSY outputs (combinational from o_sel):
  - o_valid = i_valid[o_sel]
  - o_data = i_data[o_sel]
  - o_last = i_last[o_sel]
  - o_ready[o_sel] = i_ready; o_ready of the other requester = 0.
- Transfer: o_valid & i_ready. Each transfer increments the beat counter.
- Release in BUSY, on a transfer where o_last = 1 OR beat counter = MAX_BEATS-1:
  - next state IDLE; rr_last <= o_sel; beat counter <= 0.
  - o_busy drops the next cycle.
- Forced release mid-burst: the burst continues on the owner's next grant. The downstream sees o_last only on a true last.
- Owner drops valid mid-burst: stay BUSY, o_valid = 0, grant held. There is no timeout.
- Other requester asserts valid while BUSY: ignored until release; it then wins the next IDLE if the owner also requests.
- MAX_BEATS = 1: release after every beat, giving strict beat-level alternation under contention.
- Reset mid-burst: next cycle is IDLE with all reset values; any partial burst is abandoned.
- Width rules: beat counter is $clog2(MAX_BEATS+1) bits and never wraps, because release resets it.

Optional Feature:
- Macro: MUX2_ARB_STATS_EN.
- Defined: adds output ports o_gnt_cnt0 and o_gnt_cnt1, each CNT_W bits.
  - Each counts grants issued (IDLE->BUSY transitions) to its requester.
  - Saturating at all-ones; cleared by i_rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mux2_arb_pkg: FSM state encoding (ST_IDLE = 1'b0, ST_BUSY = 1'b1) and localparam helper for the beat counter width.
- One natural sub-module: mux2_arb_rr, the registered round-robin pick (inputs valid0/1 and rr_last; output grant index).
- The data mux stays inline, or reuses the existing mux2 per bit.

Test Plan:
- Reset then idle: after i_rst, all outputs 0, o_sel = 0; no valids for 10 cycles -> FSM stays IDLE, o_busy = 0.
- Single requester: req1 sends a 3-beat burst (0xA1, 0xA2, 0xA3 with last), i_ready = 1.
  - o_busy rises after 1 cycle, o_sel = 1.
  - o_data sequence A1, A2, A3; o_last on A3.
  - Return to IDLE, rr_last = 1.
- Contention round robin: both requesters continuously send 2-beat bursts -> grant order 0,1,0,1, each with 1-cycle gaps; no beat loss or duplication versus the scoreboard.
- Backpressure: i_ready toggles 1010 during a 4-beat burst from req0 -> o_ready0 mirrors i_ready; o_data stable while o_valid & ~i_ready; 4 transfers total.
- Forced release: MAX_BEATS = 4, req0 sends a 6-beat burst while req1 is valid -> after beat 4, req1 is granted; req0 resumes beats 5-6 afterwards; o_last only on beat 6.
- Reset mid-burst plus stats (with MUX2_ARB_STATS_EN):
  - assert i_rst during beat 2 -> IDLE and counters = 0 next cycle.
  - then 3 grants to req0 -> o_gnt_cnt0 = 3.
  - CNT_W = 2 with 5 grants -> o_gnt_cnt0 saturates at 3.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared types and helpers for the two-requester round-robin arbiter (mux2_arb).
package mux2_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // The beat counter must be able to hold MAX_BEATS-1.
    function automatic int beat_cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/mux2_arb_rr.sv
// Round-robin pick between two requesters; the caller registers the result on a grant.
module mux2_arb_rr
    import mux2_arb_pkg::*;
(
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_rr_last,
    output logic o_gnt_any,
    output logic o_gnt_idx
);

    assign o_gnt_any = i_valid0 | i_valid1;
    // Under contention the requester that did not own the channel last time wins.
    assign o_gnt_idx = (i_valid0 & i_valid1) ? ~i_rr_last : i_valid1;

endmodule

// File: rtl/mux2_arb.sv
// Two-requester round-robin arbiter/sequencer driving a shared 2:1 mux.
// Optional grant statistics ports are enabled by defining MUX2_ARB_STATS_EN.
module mux2_arb
    import mux2_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid0,
    input  logic [DW-1:0] i_data0,
    input  logic          i_last0,
    output logic          o_ready0,
    input  logic          i_valid1,
    input  logic [DW-1:0] i_data1,
    input  logic          i_last1,
    output logic          o_ready1,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    input  logic          i_ready,
    output logic          o_sel,
`ifdef MUX2_ARB_STATS_EN
    output logic [CNT_W-1:0] o_gnt_cnt0,
    output logic [CNT_W-1:0] o_gnt_cnt1,
`endif
    output logic          o_busy
);

    localparam int              BCW       = beat_cnt_w(MAX_BEATS);
    localparam logic [BCW-1:0]  LAST_BEAT = BCW'(MAX_BEATS - 1);

    state_t          r_state;
    logic            r_sel;
    logic            r_rr_last;
    logic [BCW-1:0]  r_beat_cnt;

    logic            w_gnt_any;
    logic            w_gnt_idx;
    logic            w_grant;
    logic            w_busy;
    logic            w_own_valid;
    logic [DW-1:0]   w_own_data;
    logic            w_own_last;
    logic            w_xfer;
    logic            w_release;

    mux2_arb_rr u_rr (
        .i_valid0  (i_valid0),
        .i_valid1  (i_valid1),
        .i_rr_last (r_rr_last),
        .o_gnt_any (w_gnt_any),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_busy      = (r_state == ST_BUSY);
    assign w_grant     = (r_state == ST_IDLE) & w_gnt_any;

    assign w_own_valid = r_sel ? i_valid1 : i_valid0;
    assign w_own_data  = r_sel ? i_data1  : i_data0;
    assign w_own_last  = r_sel ? i_last1  : i_last0;

    assign o_valid  = w_busy & w_own_valid;
    assign o_data   = w_own_data;
    assign o_last   = w_busy & w_own_last;
    assign o_ready0 = w_busy & ~r_sel & i_ready;
    assign o_ready1 = w_busy &  r_sel & i_ready;
    assign o_sel    = r_sel;
    assign o_busy   = w_busy;

    assign w_xfer    = o_valid & i_ready;
    // The beat cap releases without touching o_last; the owner resumes on its next grant.
    assign w_release = w_xfer & (w_own_last | (r_beat_cnt == LAST_BEAT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_rr_last  <= 1'b1;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state <= ST_BUSY;
                        r_sel   <= w_gnt_idx;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_state    <= ST_IDLE;
                        r_rr_last  <= r_sel;
                        r_beat_cnt <= '0;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + BCW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MUX2_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stats
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_cnt <= '0;
                end else if (w_grant && (w_gnt_idx == 1'(gi)) && !(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign o_gnt_cnt0 = g_stats[0].r_cnt;
    assign o_gnt_cnt1 = g_stats[1].r_cnt;
`endif

endmodule

// File: tb/tb_mux2_arb.sv
// Self-checking bench for mux2_arb: directed bursts plus randomized traffic against a behavioural model.
module tb_mux2_arb;

    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 2;

    typedef struct packed { logic [7:0] d; logic l; } beat_t;
    typedef struct packed { logic s; logic [7:0] d; logic l; } xfer_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0, rdy = 1'b1;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          or0, or1, o_valid, o_last, sel, busy;
    logic [DW-1:0] o_data;
`ifdef MUX2_ARB_STATS_EN
    logic [CW-1:0] gc0, gc1;
`endif

    always #5 clk = ~clk;

    mux2_arb #(.DW(DW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid0 (v0),
        .i_data0  (d0),
        .i_last0  (l0),
        .o_ready0 (or0),
        .i_valid1 (v1),
        .i_data1  (d1),
        .i_last1  (l1),
        .o_ready1 (or1),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_last   (o_last),
        .i_ready  (rdy),
        .o_sel    (sel),
`ifdef MUX2_ARB_STATS_EN
        .o_gnt_cnt0 (gc0),
        .o_gnt_cnt1 (gc1),
`endif
        .o_busy   (busy)
    );

    // producer queues (what each source still has to send) and expected-delivery queues
    beat_t q0[$], q1[$], e0[$], e1[$];
    int    glog[$];
    xfer_t tlog[$];

    int checks = 0, errors = 0;
    int p0 = 100, p1 = 100, rmode = 0;
    bit hs0 = 0, hs1 = 0, flush = 0;

    // behavioural model state: who owns the channel, who wins the next tie
    bit    m_busy = 0, m_owner = 0, m_prefer = 0, prev_busy = 0;
    int    m_beats = 0, m_g0 = 0, m_g1 = 0;
    bit    ev;
    beat_t eb;
    int    sat_max = (1 << CW) - 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_x(input string nm, input int idx, input int s, input int d, input int l);
        checks++;
        if (idx >= tlog.size()) begin
            errors++;
            $display("FAIL %s[%0d]: transfer missing, required src=%0d data=%0h last=%0d", nm, idx, s, d, l);
        end else if (tlog[idx].s != 1'(s) || tlog[idx].d != 8'(d) || tlog[idx].l != 1'(l)) begin
            errors++;
            $display("FAIL %s[%0d]: got src=%0d data=%0h last=%0d required src=%0d data=%0h last=%0d",
                     nm, idx, tlog[idx].s, tlog[idx].d, tlog[idx].l, s, d, l);
        end
    endtask

    task automatic chk_g(input string nm, input int idx, input int exp);
        checks++;
        if (idx >= glog.size() || glog[idx] != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d required %0d (log size %0d)", nm, idx,
                     (idx < glog.size()) ? glog[idx] : -1, exp, glog.size());
        end
    endtask

    task automatic push_burst(input int src, input int n, input logic [7:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + 8'(i);
            b.l = (i == n - 1);
            if (src == 1) begin q1.push_back(b); e1.push_back(b); end
            else          begin q0.push_back(b); e0.push_back(b); end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_timeout", (q0.size() != 0 || q1.size() != 0 || m_busy) ? 1 : 0, 0);
    endtask

    // producers and downstream ready
    initial forever begin
        @(posedge clk); #1;
        if (flush) begin
            q0.delete(); q1.delete(); flush = 0;
        end else begin
            if (hs0 && q0.size() != 0) q0.delete(0);
            if (hs1 && q1.size() != 0) q1.delete(0);
        end
        v0 = (q0.size() != 0) && ($urandom_range(0, 99) < p0);
        v1 = (q1.size() != 0) && ($urandom_range(0, 99) < p1);
        if (q0.size() != 0) begin d0 = q0[0].d; l0 = q0[0].l; end
        else begin d0 = 8'($urandom); l0 = 1'b0; end
        if (q1.size() != 0) begin d1 = q1[0].d; l1 = q1[0].l; end
        else begin d1 = 8'($urandom); l1 = 1'b0; end
        case (rmode)
            1:       rdy = ~rdy;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b1;
        endcase
    end

    // compare process: model outputs, scoreboard, then advance the model
    initial forever begin
        @(negedge clk);
        if (rst) begin
            hs0 = 0; hs1 = 0; flush = 1;
            e0.delete(); e1.delete();
            m_busy = 0; m_owner = 0; m_prefer = 0; m_beats = 0;
            m_g0 = 0; m_g1 = 0; prev_busy = 0;
        end else begin
            ev = m_busy && (m_owner ? v1 : v0);
            chk("busy", busy, m_busy);
            chk("sel", sel, m_owner);
            chk("valid", o_valid, ev);
            chk("ready0", or0, m_busy && !m_owner && rdy);
            chk("ready1", or1, m_busy && m_owner && rdy);
            if (ev) begin
                chk("data", o_data, m_owner ? d1 : d0);
                chk("last", o_last, m_owner ? l1 : l0);
            end
`ifdef MUX2_ARB_STATS_EN
            chk("gnt_cnt0", gc0, m_g0);
            chk("gnt_cnt1", gc1, m_g1);
`endif
            if (busy && !prev_busy) glog.push_back(int'(sel));
            prev_busy = busy;
            hs0 = v0 && or0;
            hs1 = v1 && or1;
            if (o_valid && rdy) begin
                tlog.push_back(xfer_t'({sel, o_data, o_last}));
                if ((sel ? e1.size() : e0.size()) == 0) begin
                    chk("sb_extra_beat", 1, 0);
                end else begin
                    eb = sel ? e1.pop_front() : e0.pop_front();
                    chk("sb_data", o_data, eb.d);
                    chk("sb_last", o_last, eb.l);
                end
            end
            if (!m_busy) begin
                if (v0 || v1) begin
                    m_owner = (v0 && v1) ? m_prefer : v1;
                    m_busy  = 1;
                    m_beats = 0;
                    if (m_owner) m_g1 = (m_g1 < sat_max) ? m_g1 + 1 : m_g1;
                    else         m_g0 = (m_g0 < sat_max) ? m_g0 + 1 : m_g0;
                end
            end else if (ev && rdy) begin
                m_beats++;
                if ((m_owner ? l1 : l0) || m_beats == MB) begin
                    m_busy   = 0;
                    m_prefer = !m_owner;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready0", or0, 0);
        chk("rst_ready1", or1, 0);
        repeat (10) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
        end

        // single requester, 3-beat burst from req1
        @(posedge clk); #2;
        glog.delete(); tlog.delete();
        push_burst(1, 3, 8'hA1);
        wait_drain(100);
        chk("t2_ngrants", glog.size(), 1);
        chk_g("t2_grant", 0, 1);
        chk("t2_nxfer", tlog.size(), 3);
        chk_x("t2_x", 0, 1, 'hA1, 0);
        chk_x("t2_x", 1, 1, 'hA2, 0);
        chk_x("t2_x", 2, 1, 'hA3, 1);

        // contention with 2-beat bursts: req0 wins first because req1 owned last
        @(posedge clk); #2;
        glog.delete(); tlog.delete();
        push_burst(0, 2, 8'h10);
        push_burst(1, 2, 8'h30);
        push_burst(0, 2, 8'h20);
        push_burst(1, 2, 8'h40);
        wait_drain(200);
        chk("t3_ngrants", glog.size(), 4);
        for (int i = 0; i < 4; i++) chk_g("t3_grant", i, i % 2);
        chk("t3_nxfer", tlog.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_x("t3_x", i, (i / 2) % 2, 'h10 + 'h20 * ((i / 2) % 2) + 'h10 * (i / 4) + (i % 2), i % 2);

        // backpressure: ready toggles every cycle during a 4-beat burst
        @(posedge clk); #2;
        glog.delete(); tlog.delete();
        rmode = 1;
        push_burst(0, 4, 8'h50);
        wait_drain(100);
        rmode = 0;
        chk("t4_nxfer", tlog.size(), 4);
        for (int i = 0; i < 4; i++) chk_x("t4_x", i, 0, 'h50 + i, (i == 3) ? 1 : 0);

        // forced release after MB beats; req1 slips in, req0 resumes
        @(posedge clk); #2;
        glog.delete(); tlog.delete();
        push_burst(0, 6, 8'h61);
        @(posedge clk); #2;
        push_burst(1, 1, 8'h71);
        wait_drain(200);
        chk("t5_ngrants", glog.size(), 3);
        chk_g("t5_grant", 0, 0);
        chk_g("t5_grant", 1, 1);
        chk_g("t5_grant", 2, 0);
        chk("t5_nxfer", tlog.size(), 7);
        for (int i = 0; i < 4; i++) chk_x("t5_x", i, 0, 'h61 + i, 0);
        chk_x("t5_x", 4, 1, 'h71, 1);
        chk_x("t5_x", 5, 0, 'h65, 0);
        chk_x("t5_x", 6, 0, 'h66, 1);

        // reset in the middle of a burst
        @(posedge clk); #2;
        glog.delete(); tlog.delete();
        push_burst(0, 4, 8'h80);
        n = 0;
        while (tlog.size() < 1 && n < 50) begin @(negedge clk); n++; end
        chk("t6_first_beat_timeout", (tlog.size() < 1) ? 1 : 0, 0);
        @(posedge clk); #2 rst = 1;
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_valid", o_valid, 0);
        chk("t6_sel", sel, 0);
        chk("t6_ready0", or0, 0);
`ifdef MUX2_ARB_STATS_EN
        chk("t6_cnt0", gc0, 0);
        chk("t6_cnt1", gc1, 0);
`endif
        wait_drain(50);

        // grants after reset, then saturation of the 2-bit counter
        @(posedge clk); #2;
        glog.delete(); tlog.delete();
        for (int i = 0; i < 3; i++) push_burst(0, 1, 8'(8'h90 + i));
        wait_drain(100);
        chk("t7_ngrants", glog.size(), 3);
`ifdef MUX2_ARB_STATS_EN
        chk("t7_cnt0", gc0, 3);
`endif
        @(posedge clk); #2;
        for (int i = 0; i < 2; i++) push_burst(0, 1, 8'(8'hA0 + i));
        wait_drain(100);
        chk("t7_ngrants5", glog.size(), 5);
`ifdef MUX2_ARB_STATS_EN
        chk("t7_cnt0_sat", gc0, 3);
`endif

        // randomized traffic
        rmode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            if (c % 500 == 0) begin
                p0 = $urandom_range(40, 100);
                p1 = $urandom_range(40, 100);
            end
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (q1.size() < 20) push_burst(1, $urandom_range(1, 7), 8'($urandom));
                end else begin
                    if (q0.size() < 20) push_burst(0, $urandom_range(1, 7), 8'($urandom));
                end
            end
        end
        p0 = 100; p1 = 100; rmode = 0;
        wait_drain(3000);
        chk("rand_e0_left", e0.size(), 0);
        chk("rand_e1_left", e1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
